negator: RTL and testbench
==========================

# negator

Bit-serial two's-complement negator: consumes an operand one bit per clock, LSB first, and emits the negated operand on the same bit schedule. It implements the "copy up to and including the first 1, then invert every later bit" rule as a two-state Mealy machine. It is a building block of the serial two's-complement adder/subtractor datapath, where it forms −B ahead of the serial adder. Operand length is unbounded; a new operand starts with a reset pulse.

## Interface
- `REGISTERED_OUT`, default 0. Selects the output mode.
  - 0: `z` is combinational (Mealy), with zero latency.
  - 1: `z` is registered, with one clock of latency.
- `clk`, input, 1 bit. Single clock, rising-edge active.
- `reset`, input, 1 bit. Asynchronous, active-high. Returns the FSM to its initial state.
- `en`, input, 1 bit. Bit-enable. State (and the output register, when present) advance only on rising edges where `en`=1.
- `x`, input, 1 bit. Serial operand bit, LSB first.
- `z`, output, 1 bit. Serial negated bit, LSB first.

## Operation
- States:
  - COPY (encoding 0, reset state): no 1 has been seen yet in the current operand.
  - INVERT (encoding 1): a 1 has already been consumed.
- Transitions, evaluated on a rising `clk` edge with `en`=1:
  - COPY with `x`=0 stays in COPY.
  - COPY with `x`=1 moves to INVERT.
  - INVERT stays in INVERT for any `x`.
- With `en`=0, the state holds.
- Output function, f = (state==COPY) ? `x` : ~`x`. The first 1 itself is copied; inversion starts with the next bit.
- `REGISTERED_OUT`=0: `z` = f(state, `x`) continuously. `en` does not gate `z`; `z` keeps tracking `x` while `en`=0.
- `REGISTERED_OUT`=1: `z` is loaded with f(state, `x`) on each enabled edge and holds otherwise.
- Arithmetic rules:
  - The result is the N-bit two's-complement negation for whatever N the caller frames between resets.
  - The most-negative value (1 followed by N−1 zeros, MSB first) maps to itself. No overflow flag is produced.
  - An all-zero operand yields all-zero output.
- Reset, asynchronous and taking effect immediately:
  - State is forced to COPY.
  - The output register, when present, is forced to 0.
  - `REGISTERED_OUT`=0: `z` = `x` while in reset.
- Reset has priority over `en`. Reset mid-operand abandons the current operand; the next enabled bit after release is treated as the LSB of a new operand.
- Undriven/X on `x` must not corrupt state while `en`=0.

## Timing
- Callers change `x` and `en` away from the rising edge, e.g. on the falling half-cycle. The bench drives them 5 ns after each edge of a 10 ns clock.
- `REGISTERED_OUT`=0:
  - `z` for bit k is valid in the same cycle `x` bit k is presented.
  - The state update caused by bit k affects `z` starting with bit k+1.
- `REGISTERED_OUT`=1: `z` for bit k appears after the edge that samples bit k, and is held until the next enabled edge.
- Reset release: the first rising edge with `reset`=0 and `en`=1 consumes the LSB.
- Reset asserted coincident with an edge: the reset wins and the state is COPY.
- No handshake beyond `en`. One bit is consumed per enabled edge, with no backpressure.

## Test plan
- Negate −4, 4-bit. Reset, then `x` = 0,0,1,1 (LSB first) with `en`=1. Required `z` = 0,0,1,0, i.e. +4 (0100).
- Negate +26, 6-bit. Reset, then `x` = 0,1,0,1,1,0. Required `z` = 0,1,1,0,0,1, i.e. −26 (100110). The state enters INVERT after the second bit.
- Edge values.
  - −8, 4-bit: `x` = 0,0,0,1. Required `z` = 0,0,0,1 (self-negation).
  - 0: `x` = 0,0,0,0. Required `z` = 0,0,0,0 with the state remaining COPY.
- Enable hold. Feed 0,1; drop `en` for 3 edges while toggling `x`; then feed 0,1.
  - Required: the state stays INVERT through the gap.
  - Required: the post-gap `z` = 1,0.
- Asynchronous reset mid-operand. After INVERT is reached, pulse `reset` between edges.
  - Required: the state is COPY immediately, `z` = `x`.
  - Required: the next operand 0,1,1 yields 0,1,0.
- `REGISTERED_OUT`=1. Repeat the −4 case. Required: the same `z` sequence delayed by one clock, and `z`=0 during reset.

Source files
------------

// File: rtl/negator.sv
// ----------------------------------------------------------------------------
// negator
//   Bit-serial two's-complement negator. Operand bits arrive LSB first, one
//   per enabled clock edge. Output bits follow the "copy up to and including
//   the first 1, then invert every later bit" rule. A reset pulse frames the
//   start of a new operand. Operand length is unbounded.
//
// Parameters
//   REGISTERED_OUT : 0 -> z is combinational (Mealy, zero latency)
//                    1 -> z is registered (one clock of latency)
//
// Ports
//   clk   : clock, rising-edge active
//   reset : asynchronous, active-high; forces COPY and clears the output reg
//   en    : bit enable; state and output register advance only when set
//   x     : serial operand bit, LSB first
//   z     : serial negated bit, LSB first
// ----------------------------------------------------------------------------
module negator #(
    parameter bit REGISTERED_OUT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic x,
    output logic z
);

    typedef enum logic {
        COPY   = 1'b0,   // no 1 seen yet in this operand
        INVERT = 1'b1    // a 1 has been consumed; invert from here on
    } state_t;

    state_t state;
    logic   f;

    // The bit that carries the first 1 is still copied; inversion only
    // applies once the state has moved, i.e. from the following bit.
    always_comb begin
        f = (state == COPY) ? x : ~x;
    end

    // INVERT is absorbing, so only COPY needs a transition. The en test
    // comes first so an undriven x cannot disturb state while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= COPY;
        end else if (en) begin
            if (state == COPY && x == 1'b1)
                state <= INVERT;
        end
    end

    generate
        if (REGISTERED_OUT) begin : g_reg_out
            logic z_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    z_q <= 1'b0;
                else if (en)
                    z_q <= f;
            end

            assign z = z_q;
        end else begin : g_comb_out
            // Not gated by en: z keeps tracking x between enabled edges.
            assign z = f;
        end
    endgenerate

endmodule

// File: tb/tb_negator.sv
// ----------------------------------------------------------------------------
// tb_negator
//   Directed bench for negator. Two instances share stimulus: one with a
//   combinational output (z0) and one with a registered output (z1).
//   Inputs change on the falling edge; z0 is sampled 2 ns later, z1 1 ns
//   after the following rising edge.
// ----------------------------------------------------------------------------
module tb_negator;

    logic clk;
    logic reset;
    logic en;
    logic x;
    logic z0;
    logic z1;

    int total;
    int passed;

    negator #(.REGISTERED_OUT(1'b0)) dut_comb (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .x     (x),
        .z     (z0)
    );

    negator #(.REGISTERED_OUT(1'b1)) dut_reg (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .x     (x),
        .z     (z1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame a new operand: short reset pulse between edges.
    task automatic pulse_reset();
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; x = 1'b1;
        #2;
        total++;
        if (z0 !== 1'b1) $display("FAIL reset_comb_x1: z=%b expected 1", z0);
        else passed++;
        total++;
        if (z1 !== 1'b0) $display("FAIL reset_reg_zero: z=%b expected 0", z1);
        else passed++;
        x = 1'b0;
        #1;
        total++;
        if (z0 !== 1'b0) $display("FAIL reset_comb_x0: z=%b expected 0", z0);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // -4 (1100) -> +4 (0100), both output modes.
    task automatic test_neg_m4();
        logic [3:0] xs;
        logic [3:0] zs;
        xs = 4'b1100;
        zs = 4'b0100;
        pulse_reset();
        #1;
        total++;
        if (z1 !== 1'b0) $display("FAIL m4_reg_pre: z=%b expected 0", z1);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = xs[i]; en = 1'b1;
            #2;
            total++;
            if (z0 !== zs[i]) $display("FAIL m4_comb bit%0d: z=%b expected %b", i, z0, zs[i]);
            else passed++;
            @(posedge clk);
            #1;
            total++;
            if (z1 !== zs[i]) $display("FAIL m4_reg bit%0d: z=%b expected %b", i, z1, zs[i]);
            else passed++;
        end
    endtask

    // +26 (011010) -> -26 (100110).
    task automatic test_neg_p26();
        logic [5:0] xs;
        logic [5:0] zs;
        xs = 6'b011010;
        zs = 6'b100110;
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            x = xs[i]; en = 1'b1;
            #2;
            total++;
            if (z0 !== zs[i]) $display("FAIL p26 bit%0d: z=%b expected %b", i, z0, zs[i]);
            else passed++;
        end
    endtask

    // -8 maps to itself; zero maps to zero and leaves the FSM in COPY.
    task automatic test_edge_values();
        logic [3:0] xs;
        xs = 4'b1000;
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = xs[i]; en = 1'b1;
            #2;
            total++;
            if (z0 !== xs[i]) $display("FAIL m8 bit%0d: z=%b expected %b", i, z0, xs[i]);
            else passed++;
        end
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = 1'b0; en = 1'b1;
            #2;
            total++;
            if (z0 !== 1'b0) $display("FAIL zero bit%0d: z=%b expected 0", i, z0);
            else passed++;
        end
        // Still COPY: a 1 on x passes straight through.
        @(negedge clk);
        x = 1'b1; en = 1'b0;
        #2;
        total++;
        if (z0 !== 1'b1) $display("FAIL zero_state_copy: z=%b expected 1", z0);
        else passed++;
    endtask

    // Feed 0,1; hold en low for 3 edges with x toggling; then feed 0,1.
    task automatic test_enable_hold();
        logic [1:0] pre;
        logic [2:0] gap;
        logic [1:0] post;
        logic [1:0] zpost;
        pre = 2'b10; gap = 3'b101; post = 2'b10; zpost = 2'b01;
        pulse_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            x = pre[i]; en = 1'b1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x = gap[i]; en = 1'b0;
            #2;
            total++;
            if (z0 !== ~gap[i]) $display("FAIL hold_comb gap%0d: z=%b expected %b", i, z0, ~gap[i]);
            else passed++;
            @(posedge clk);
            #1;
            total++;
            if (z1 !== 1'b1) $display("FAIL hold_reg gap%0d: z=%b expected 1", i, z1);
            else passed++;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            x = post[i]; en = 1'b1;
            #2;
            total++;
            if (z0 !== zpost[i]) $display("FAIL hold_post bit%0d: z=%b expected %b", i, z0, zpost[i]);
            else passed++;
            @(posedge clk);
            #1;
            total++;
            if (z1 !== zpost[i]) $display("FAIL hold_post_reg bit%0d: z=%b expected %b", i, z1, zpost[i]);
            else passed++;
        end
    endtask

    // Reset between edges after INVERT is reached, then a fresh operand.
    task automatic test_async_reset();
        logic [2:0] xs;
        logic [2:0] zs;
        xs = 3'b110; zs = 3'b010;
        pulse_reset();
        @(negedge clk);
        x = 1'b1; en = 1'b1;
        @(negedge clk);
        x = 1'b1; en = 1'b0;
        #1;
        total++;
        if (z0 !== 1'b0) $display("FAIL areset_pre_invert: z=%b expected 0", z0);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if (z0 !== 1'b1) $display("FAIL areset_comb_follow: z=%b expected 1", z0);
        else passed++;
        total++;
        if (z1 !== 1'b0) $display("FAIL areset_reg_clear: z=%b expected 0", z1);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (z0 !== 1'b1) $display("FAIL areset_state_copy: z=%b expected 1", z0);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x = xs[i]; en = 1'b1;
            #2;
            total++;
            if (z0 !== zs[i]) $display("FAIL areset_next bit%0d: z=%b expected %b", i, z0, zs[i]);
            else passed++;
            @(posedge clk);
            #1;
            total++;
            if (z1 !== zs[i]) $display("FAIL areset_next_reg bit%0d: z=%b expected %b", i, z1, zs[i]);
            else passed++;
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        en     = 1'b0;
        x      = 1'b0;
        test_reset();
        test_neg_m4();
        test_neg_p26();
        test_edge_values();
        test_enable_hold();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
